// File: rtl/counter_pkg.sv
// Shared types and constants for the two-digit BCD seconds counter.
// Latency: n/a (types only).
// Backpressure: n/a.
package counter_pkg;

  // One decimal digit in BCD; legal values are 0..BCD_MAX.
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Packed seconds reading as presented to the display/readout logic.
  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_reading_t;

endpackage

// File: rtl/counter_bcd_digit.sv
// Single BCD digit register counting 0..9 with wrap, chainable via carry.
// Latency: value updates on the clk edge where inc_in is high; carry_out is combinational.
// Backpressure: none; every inc_in pulse is consumed on the same edge.
//
// Ports:
//   clk        rising-edge clock
//   init_regs  asynchronous active-low clear
//   inc_in     advance the digit by one on this edge
//   carry_out  high when inc_in is high and the digit is about to wrap 9 -> 0
//   value      current digit value, always 0..9
module bcd_digit
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       init_regs,
  input  logic       inc_in,
  output logic       carry_out,
  output bcd_digit_t value
);

  assign carry_out = inc_in && (value == BCD_MAX);

  always_ff @(posedge clk or negedge init_regs) begin
    if (!init_regs) begin
      value <= '0;
    end else if (inc_in) begin
      // Wrapping through carry_out keeps the digit out of the 10..15 range.
      value <= carry_out ? '0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/counter.sv
// Two-digit BCD seconds counter (00..99) driven by a CLK_FREQ-cycle prescaler.
// Latency: time_reading updates on the same edge as the internal one-second tick (registered output).
// Backpressure: none; count_enabled=0 freezes both the prescaler phase and the reading.
//
// Ports:
//   clk            rising-edge clock
//   init_regs      asynchronous active-low clear, released synchronously to clk
//   count_enabled  level: 1 = run, 0 = pause
//   sec_tick       one-cycle pulse coinciding with each reading update
//                  (present only when COUNTER_SEC_TICK_EN is defined)
//   time_reading   packed BCD {tens, ones}
//
// Build option: define COUNTER_SEC_TICK_EN to add the sec_tick output.
module counter
  import counter_pkg::*;
#(
  parameter int CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic       count_enabled,
`ifdef COUNTER_SEC_TICK_EN
  output logic       sec_tick,
`endif
  output logic [7:0] time_reading
);

  // CLK_FREQ >= 2 is required; the guard only keeps the width legal.
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          ones_carry;
  logic          tens_carry_unused;
  bcd_digit_t    ones_val;
  bcd_digit_t    tens_val;
  bcd_reading_t  reading;

  // The tick fires on the enabled edge where the prescaler sits at its
  // terminal count, i.e. on the CLK_FREQ-th enabled edge of each second.
  assign tick = count_enabled && (presc == PRESC_TERM);

  always_ff @(posedge clk or negedge init_regs) begin
    if (!init_regs) begin
      presc <= '0;
    end else if (count_enabled) begin
      presc <= (presc == PRESC_TERM) ? '0 : presc + PW'(1);
    end
  end

  bcd_digit u_ones (
    .clk       (clk),
    .init_regs (init_regs),
    .inc_in    (tick),
    .carry_out (ones_carry),
    .value     (ones_val)
  );

  // The tens carry marks the 99 -> 00 wrap; both digits already wrap on
  // their own, so nothing downstream needs it.
  bcd_digit u_tens (
    .clk       (clk),
    .init_regs (init_regs),
    .inc_in    (ones_carry),
    .carry_out (tens_carry_unused),
    .value     (tens_val)
  );

  assign reading.tens = tens_val;
  assign reading.ones = ones_val;
  assign time_reading = reading;

`ifdef COUNTER_SEC_TICK_EN
  always_ff @(posedge clk or negedge init_regs) begin
    if (!init_regs) begin
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
    end
  end
`endif

endmodule

// File: tb/tb_counter.sv
module tb_counter;

  localparam int CLK_FREQ = 10;

  logic       clk;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] time_reading;
`ifdef COUNTER_SEC_TICK_EN
  logic       sec_tick;
`endif

  int n_vec;
  int n_bad;

  counter #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk           (clk),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
`ifdef COUNTER_SEC_TICK_EN
    .sec_tick      (sec_tick),
`endif
    .time_reading  (time_reading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    int         cycles;
    logic [7:0] exp_reading;
    int         exp_ticks;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input int c,
                              input logic [7:0] x, input int t);
    vec_t v;
    v.rst_n = r; v.en = e; v.cycles = c; v.exp_reading = x; v.exp_ticks = t;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Runs n clock edges, sampling 1 ns after each edge. Counts sec_tick
  // pulses and, with the tick output present, checks that every pulse
  // coincides with a change of the reading and vice versa.
  task automatic run(input int n, output int ticks);
    logic [7:0] prev;
    ticks = 0;
    prev  = time_reading;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
`ifdef COUNTER_SEC_TICK_EN
      if (sec_tick === 1'b1) ticks++;
      check("tick_vs_update", int'(sec_tick), int'(time_reading != prev));
`endif
      prev = time_reading;
    end
  endtask

  initial begin
    int ticks;
    n_vec = 0;
    n_bad = 0;

    // rst, en, cycles, expected reading, expected sec_tick pulses
    add(1'b0, 1'b1,   0, 8'h00,  0);  // reset state, immediately
    add(1'b0, 1'b1,   5, 8'h00,  0);  // reset overrides enable
    add(1'b1, 1'b1,   9, 8'h00,  0);  // not yet a full second
    add(1'b1, 1'b1,   1, 8'h01,  1);  // 10th enabled edge
    add(1'b1, 1'b1,  10, 8'h02,  1);
    add(1'b1, 1'b1,   4, 8'h02,  0);  // prescaler now at 4
    add(1'b1, 1'b0,  20, 8'h02,  0);  // pause holds everything
    add(1'b1, 1'b1,   5, 8'h02,  0);  // partial second retained
    add(1'b1, 1'b1,   1, 8'h03,  1);  // 6 enabled edges after resume
    add(1'b1, 1'b1,  60, 8'h09,  6);
    add(1'b1, 1'b1,  10, 8'h10,  1);  // ones carry into tens
    add(1'b1, 1'b1, 890, 8'h99, 89);
    add(1'b1, 1'b1,   9, 8'h99,  0);
    add(1'b1, 1'b1,   1, 8'h00,  1);  // 99 -> 00 wrap with tick
    add(1'b1, 1'b1, 370, 8'h37, 37);

    init_regs     = 1'b1;
    count_enabled = 1'b0;
    #1;
    init_regs     = 1'b0;
    count_enabled = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      init_regs     = vecs[i].rst_n;
      count_enabled = vecs[i].en;
      #1;
      run(vecs[i].cycles, ticks);
      check($sformatf("vec%0d_reading", i), int'(time_reading), int'(vecs[i].exp_reading));
`ifdef COUNTER_SEC_TICK_EN
      check($sformatf("vec%0d_ticks", i), ticks, vecs[i].exp_ticks);
`endif
    end

    // Async reset mid-second: advance the prescaler, then pulse init_regs
    // low between edges and observe the clear before the next edge.
    run(3, ticks);
    check("pre_reset_reading", int'(time_reading), 'h37);
    #2;
    init_regs = 1'b0;
    #1;
    check("async_clear_reading", int'(time_reading), 'h00);
`ifdef COUNTER_SEC_TICK_EN
    check("async_clear_tick", int'(sec_tick), 0);
`endif
    #2;
    init_regs = 1'b1;
    // A retained phase of 3 would tick after 7 edges; a cleared one needs 10.
    run(9, ticks);
    check("post_reset_9", int'(time_reading), 'h00);
    run(1, ticks);
    check("post_reset_10", int'(time_reading), 'h01);
`ifdef COUNTER_SEC_TICK_EN
    check("post_reset_tick", ticks, 1);
`endif

    // Reset while paused, then resume: full second still required.
    count_enabled = 1'b0;
    run(4, ticks);
    init_regs = 1'b0;
    #1;
    check("paused_reset_reading", int'(time_reading), 'h00);
    init_regs     = 1'b1;
    count_enabled = 1'b1;
    run(9, ticks);
    check("paused_reset_9", int'(time_reading), 'h00);
    run(1, ticks);
    check("paused_reset_10", int'(time_reading), 'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Two-digit BCD seconds counter (00-99) for the stopwatch datapath.
- A clock-cycle prescaler derives a one-second tick from clk.
- The tick advances a packed BCD reading {tens, ones} that feeds the display/readout logic.
- Counting is gated by count_enabled. Pausing freezes both the reading and the prescaler phase.

Parameters:
- CLK_FREQ, default 100000000: clk cycles per second. Legal range is >= 2. Sets the prescaler terminal count to CLK_FREQ-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- init_regs  input  1  asynchronous, active-low reset. At 0 it immediately clears all state; release is synchronous to clk.
- count_enabled  input  1  level; 1 = run, 0 = pause.
- time_reading  output  8  packed BCD seconds: [7:4] = tens digit 0-9, [3:0] = ones digit 0-9.

Behaviour:
- Reset (init_regs = 0): prescaler = 0, ones = 0, tens = 0, time_reading = 8'h00, sec_tick = 0 when present. Reset overrides count_enabled.
- Prescaler:
  - Unsigned, width $clog2(CLK_FREQ).
  - On each clk edge with count_enabled = 1: if prescaler == CLK_FREQ-1, it wraps to 0 and generates a one-cycle internal tick; otherwise it increments by 1.
  - With count_enabled = 0 it holds its value; it does not clear on pause.
- Tick timing: the first tick occurs on the CLK_FREQ-th enabled rising edge after reset release. With 100 MHz, the reading becomes 01 exactly 1 s of enabled time after enable.
- On tick:
  - ones < 9: ones + 1.
  - ones == 9: ones = 0 and tens increments.
  - tens == 9 and ones == 9: both digits wrap to 0 (99 -> 00). No saturation, no overflow flag.
- time_reading is registered, changing in the same edge as the tick. No combinational path from inputs to the output.
- count_enabled toggling mid-second: the accumulated partial second is retained. The total enabled cycles per increment is always exactly CLK_FREQ.
- Digits never hold values 10-15. Illegal values cannot arise from reset or counting.
- Reset asserted mid-count: the output returns to 00 asynchronously, and the prescaler phase is lost.

Optional Feature:
- Macro: COUNTER_SEC_TICK_EN.
- Defined: adds output port sec_tick (1 bit). It pulses high for exactly one clk cycle, registered, in the same cycle time_reading updates. It is also asserted on the 99 -> 00 wrap. It is 0 in reset.
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Shared package counter_pkg holds:
  - BCD digit typedef (logic [3:0]);
  - constant BCD_MAX = 4'd9;
  - packed reading typedef {tens, ones}.
- One natural sub-module, bcd_digit. It has ports clk, init_regs, inc_in and carry_out, plus value[3:0]. It increments 0-9 with wrap and asserts carry_out combinationally when inc_in && value == 9.
- counter instantiates the prescaler inline and chains two bcd_digit instances (ones.carry_out -> tens.inc_in).

Test Plan (CLK_FREQ = 10 for speed unless noted):
- Reset, then enable: hold init_regs = 0 for 5 cycles with count_enabled = 1 -> time_reading stays 00. Release and run 10 enabled cycles -> 01 after the 10th edge, not before.
- Continuous run for 20 more cycles -> 02 then 03. sec_tick pulses exactly once per 10 cycles (COUNTER_SEC_TICK_EN defined).
- Pause: at reading 02 with prescaler at 4, drop count_enabled for 20 cycles -> reading stays 02. Re-enable -> 03 after exactly 6 more enabled cycles.
- Carry and wrap:
  - run to 09, one more tick -> 10;
  - run to 99, one more tick -> 00, with sec_tick high on that cycle.
- Async reset mid-count: at reading 37, pulse init_regs low between clock edges -> output 00 immediately, before the next edge. After release, 10 enabled cycles -> 01.
- CLK_FREQ = 100000000, 100 MHz clk: enable for 1 s -> 8'h01; for 2 s -> 8'h02; a 200 ns pause -> still 8'h02.
